id_ex_stage: RTL and testbench

Pipeline register between decode and execute. It captures the decoder control bundle and the operands from the register file and immediate generator, and presents them to EX one cycle later. It detects load-use hazards on both the integer and the FP register file, inserts bubbles for them, and applies downstream stall and branch/jump flush. The decode/fetch stall request is produced here.

---
 rtl/id_ex_stage_pkg.sv | 102 ++++++++++
 rtl/id_ex_stage_if.sv | 54 +++++
 rtl/id_ex_hazard.sv | 30 +++
 rtl/id_ex_stage.sv | 101 ++++++++++
 tb/tb_id_ex_stage.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register: opcode and
// writeback-select encodings, the decoder control bundle, the bubble value
// and helpers that decode which source registers an opcode reads.
package id_ex_stage_pkg;

    localparam int XLEN = 32;

    // RV32 major opcodes
    localparam logic [6:0] OP_LOAD           = 7'b0000011;
    localparam logic [6:0] OP_FP_LOAD        = 7'b0000111;
    localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
    localparam logic [6:0] OP_AUIPC          = 7'b0010111;
    localparam logic [6:0] OP_STORE          = 7'b0100011;
    localparam logic [6:0] OP_FP_STORE       = 7'b0100111;
    localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
    localparam logic [6:0] OP_LUI            = 7'b0110111;
    localparam logic [6:0] OP_FP_ARITHMETIC  = 7'b1010011;
    localparam logic [6:0] OP_BRANCH         = 7'b1100011;
    localparam logic [6:0] OP_JALR           = 7'b1100111;
    localparam logic [6:0] OP_JAL            = 7'b1101111;
    localparam logic [6:0] OP_CSR            = 7'b1110011;

    // Writeback source select
    localparam logic [2:0] ALU_RESULT   = 3'd0;
    localparam logic [2:0] LOAD_DATA    = 3'd1;
    localparam logic [2:0] PC_PLUS_4    = 3'd2;
    localparam logic [2:0] IMM_DATA     = 3'd3;
    localparam logic [2:0] FP_LOAD_DATA = 3'd4;
    localparam logic [2:0] CSR_DATA     = 3'd5;
    localparam logic [2:0] FP_RESULT    = 3'd6;

    // Decoder control bundle, field order fixed by the decoder
    typedef struct packed {
        logic [3:0] alu_sel;
        logic [2:0] alu_use_sel_1;
        logic [1:0] alu_use_sel_2;
        logic       fp_sub;
        logic       write;
        logic       write_fp;
        logic [2:0] mem_to_wb_sel;
        logic       WEB;
        logic [1:0] BWEB_pre;
        logic       fp_store;
        logic       jump;
        logic       branch;
    } id_ex_ctrl_t;

    // A bubble has no architectural side effect: no register write,
    // memory write-enable (active low) deasserted, no control transfer.
    localparam id_ex_ctrl_t ID_EX_BUBBLE = '{
        alu_sel:       4'd0,
        alu_use_sel_1: 3'd0,
        alu_use_sel_2: 2'd0,
        fp_sub:        1'b0,
        write:         1'b0,
        write_fp:      1'b0,
        mem_to_wb_sel: 3'd0,
        WEB:           1'b1,
        BWEB_pre:      2'd0,
        fp_store:      1'b0,
        jump:          1'b0,
        branch:        1'b0
    };

    // Operand payload carried alongside the control bundle
    typedef struct packed {
        logic [2:0]      funct3;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] frs1_data;
        logic [XLEN-1:0] frs2_data;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } id_ex_data_t;

    function automatic logic uses_int_rs1(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_FP_LOAD, OP_STORE, OP_FP_STORE, OP_BRANCH,
            OP_JALR, OP_ARITHMETIC_IMM, OP_ARITHMETIC, OP_CSR: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

    function automatic logic uses_int_rs2(input logic [6:0] opcode);
        case (opcode)
            OP_STORE, OP_BRANCH, OP_ARITHMETIC: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic uses_fp_rs1(input logic [6:0] opcode);
        return opcode == OP_FP_ARITHMETIC;
    endfunction

    function automatic logic uses_fp_rs2(input logic [6:0] opcode);
        return (opcode == OP_FP_ARITHMETIC) || (opcode == OP_FP_STORE);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode, the ID/EX register and execute.
// master = decode/EX side driving ID inputs and stall/flush; slave = the stage.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic            i_valid;
    logic [6:0]      i_opcode;
    logic [2:0]      i_funct3;
    id_ex_ctrl_t     i_ctrl;
    logic [XLEN-1:0] i_pc;
    logic [XLEN-1:0] i_imm;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;
    logic [XLEN-1:0] i_frs1_data;
    logic [XLEN-1:0] i_frs2_data;
    logic [4:0]      i_rs1;
    logic [4:0]      i_rs2;
    logic [4:0]      i_rd;
    logic            i_ex_stall;
    logic            i_flush;

    logic            o_valid;
    id_ex_ctrl_t     o_ctrl;
    logic [2:0]      o_funct3;
    logic [XLEN-1:0] o_pc;
    logic [XLEN-1:0] o_imm;
    logic [XLEN-1:0] o_rs1_data;
    logic [XLEN-1:0] o_rs2_data;
    logic [XLEN-1:0] o_frs1_data;
    logic [XLEN-1:0] o_frs2_data;
    logic [4:0]      o_rs1;
    logic [4:0]      o_rs2;
    logic [4:0]      o_rd;
    logic            o_id_stall;

    modport master (
        output i_valid, i_opcode, i_funct3, i_ctrl, i_pc, i_imm,
               i_rs1_data, i_rs2_data, i_frs1_data, i_frs2_data,
               i_rs1, i_rs2, i_rd, i_ex_stall, i_flush,
        input  o_valid, o_ctrl, o_funct3, o_pc, o_imm,
               o_rs1_data, o_rs2_data, o_frs1_data, o_frs2_data,
               o_rs1, o_rs2, o_rd, o_id_stall
    );

    modport slave (
        input  i_valid, i_opcode, i_funct3, i_ctrl, i_pc, i_imm,
               i_rs1_data, i_rs2_data, i_frs1_data, i_frs2_data,
               i_rs1, i_rs2, i_rd, i_ex_stall, i_flush,
        output o_valid, o_ctrl, o_funct3, o_pc, o_imm,
               o_rs1_data, o_rs2_data, o_frs1_data, o_frs2_data,
               o_rs1, o_rs2, o_rd, o_id_stall
    );

endinterface

// File: rtl/id_ex_hazard.sv
// Load-use hazard detector: flags an ID instruction that reads the
// destination of a load currently sitting in EX, per register file.
module id_ex_hazard
    import id_ex_stage_pkg::*;
(
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_int_load,
    input  logic       ex_fp_load,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    logic int_hit;
    logic fp_hit;

    // Integer x0 is hardwired so it never creates a dependency; f0 is real.
    always_comb begin
        int_hit  = ex_int_load && (ex_rd != 5'd0) &&
                   ((uses_int_rs1(id_opcode) && (id_rs1 == ex_rd)) ||
                    (uses_int_rs2(id_opcode) && (id_rs2 == ex_rd)));
        fp_hit   = ex_fp_load &&
                   ((uses_fp_rs1(id_opcode) && (id_rs1 == ex_rd)) ||
                    (uses_fp_rs2(id_opcode) && (id_rs2 == ex_rd)));
        load_use = id_valid && (int_hit || fp_hit);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Captures decode control and operands, inserts
// bubbles for load-use hazards and flushes, and holds under EX stall.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    id_ex_stage_if.slave bus
);

    logic        valid_q, valid_d;
    id_ex_ctrl_t ctrl_q,  ctrl_d;
    id_ex_data_t data_q,  data_d;
    id_ex_data_t id_data;
    logic        ex_int_load;
    logic        ex_fp_load;
    logic        load_use;
    logic        id_stall;

    assign id_data = '{
        funct3:    bus.i_funct3,
        pc:        bus.i_pc,
        imm:       bus.i_imm,
        rs1_data:  bus.i_rs1_data,
        rs2_data:  bus.i_rs2_data,
        frs1_data: bus.i_frs1_data,
        frs2_data: bus.i_frs2_data,
        rs1:       bus.i_rs1,
        rs2:       bus.i_rs2,
        rd:        bus.i_rd
    };

    // The load in EX is whatever the register currently holds
    assign ex_int_load = valid_q && ctrl_q.write    && (ctrl_q.mem_to_wb_sel == LOAD_DATA);
    assign ex_fp_load  = valid_q && ctrl_q.write_fp && (ctrl_q.mem_to_wb_sel == FP_LOAD_DATA);

    id_ex_hazard u_hazard (
        .id_valid    (bus.i_valid),
        .id_opcode   (bus.i_opcode),
        .id_rs1      (bus.i_rs1),
        .id_rs2      (bus.i_rs2),
        .ex_int_load (ex_int_load),
        .ex_fp_load  (ex_fp_load),
        .ex_rd       (data_q.rd),
        .load_use    (load_use)
    );

    // Next-state priority: EX stall holds, flush beats load-use, else capture.
    // A flush wins over load-use without stalling because the ID instruction
    // is being discarded upstream anyway.
    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        data_d   = data_q;
        id_stall = 1'b0;
        if (bus.i_ex_stall) begin
            id_stall = 1'b1;
        end else if (bus.i_flush) begin
            valid_d  = 1'b0;
            ctrl_d   = ID_EX_BUBBLE;
            data_d   = '0;
        end else if (load_use) begin
            valid_d  = 1'b0;
            ctrl_d   = ID_EX_BUBBLE;
            data_d   = '0;
            id_stall = 1'b1;
        end else begin
            valid_d  = bus.i_valid;
            ctrl_d   = bus.i_ctrl;
            data_d   = id_data;
        end
    end

    // Stage register; reset leaves EX holding a bubble
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= ID_EX_BUBBLE;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_ctrl      = ctrl_q;
    assign bus.o_funct3    = data_q.funct3;
    assign bus.o_pc        = data_q.pc;
    assign bus.o_imm       = data_q.imm;
    assign bus.o_rs1_data  = data_q.rs1_data;
    assign bus.o_rs2_data  = data_q.rs2_data;
    assign bus.o_frs1_data = data_q.frs1_data;
    assign bus.o_frs2_data = data_q.frs2_data;
    assign bus.o_rs1       = data_q.rs1;
    assign bus.o_rs2       = data_q.rs2;
    assign bus.o_rd        = data_q.rd;
    assign bus.o_id_stall  = id_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for the ID/EX register: hazards, flush, stall, reset.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    id_ex_stage_if bus();

    id_ex_stage dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic id_ex_ctrl_t mk_ctrl(input logic wr, input logic wr_fp,
                                            input logic [2:0] wb, input logic web,
                                            input logic [1:0] bweb, input logic jmp);
        id_ex_ctrl_t c;
        c               = ID_EX_BUBBLE;
        c.alu_sel       = 4'd1;
        c.write         = wr;
        c.write_fp      = wr_fp;
        c.mem_to_wb_sel = wb;
        c.WEB           = web;
        c.BWEB_pre      = bweb;
        c.jump          = jmp;
        return c;
    endfunction

    task automatic drive(input logic [6:0] opc, input id_ex_ctrl_t c,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] imm);
        bus.i_valid     = 1'b1;
        bus.i_opcode    = opc;
        bus.i_funct3    = 3'd2;
        bus.i_ctrl      = c;
        bus.i_pc        = pc;
        bus.i_imm       = imm;
        bus.i_rs1_data  = pc + 32'd1;
        bus.i_rs2_data  = pc + 32'd2;
        bus.i_frs1_data = pc + 32'd3;
        bus.i_frs2_data = pc + 32'd4;
        bus.i_rs1       = rs1;
        bus.i_rs2       = rs2;
        bus.i_rd        = rd;
    endtask

    id_ex_ctrl_t c_lw, c_flw, c_add, c_fadd, c_fsw, c_sw, c_jalr;

    initial begin
        checks = 0;
        errors = 0;
        c_lw   = mk_ctrl(1'b1, 1'b0, LOAD_DATA,    1'b1, 2'b00, 1'b0);
        c_flw  = mk_ctrl(1'b0, 1'b1, FP_LOAD_DATA, 1'b1, 2'b00, 1'b0);
        c_add  = mk_ctrl(1'b1, 1'b0, ALU_RESULT,   1'b1, 2'b00, 1'b0);
        c_fadd = mk_ctrl(1'b0, 1'b1, FP_RESULT,    1'b1, 2'b00, 1'b0);
        c_fsw  = mk_ctrl(1'b0, 1'b0, ALU_RESULT,   1'b0, 2'b11, 1'b0);
        c_fsw.fp_store = 1'b1;
        c_sw   = mk_ctrl(1'b0, 1'b0, ALU_RESULT,   1'b0, 2'b10, 1'b0);
        c_jalr = mk_ctrl(1'b1, 1'b0, PC_PLUS_4,    1'b1, 2'b00, 1'b1);

        // Reset with random ID inputs
        rst_n          = 1'b0;
        bus.i_ex_stall = 1'b0;
        bus.i_flush    = 1'($urandom);
        drive(7'($urandom), id_ex_ctrl_t'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), $urandom, $urandom);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bus.o_valid, 0);
        check("rst_web", bus.o_ctrl.WEB, 1);
        check("rst_write", bus.o_ctrl.write, 0);
        check("rst_id_stall", bus.o_id_stall, 0);
        rst_n       = 1'b1;
        bus.i_flush = 1'b0;

        // Integer load-use: lw x5 then add x6,x5,x1
        drive(OP_LOAD, c_lw, 5'd1, 5'd0, 5'd5, 32'h10, 32'h0);
        step();
        check("lw_in_ex_valid", bus.o_valid, 1);
        drive(OP_ARITHMETIC, c_add, 5'd5, 5'd1, 5'd6, 32'h14, 32'h0);
        #1 check("int_lu_stall", bus.o_id_stall, 1);
        step();
        check("int_lu_bubble_valid", bus.o_valid, 0);
        check("int_lu_bubble_write", bus.o_ctrl.write, 0);
        check("int_lu_stall_gone", bus.o_id_stall, 0);
        step();
        check("add_arrives_valid", bus.o_valid, 1);
        check("add_arrives_rd", bus.o_rd, 6);
        check("add_arrives_rs1", bus.o_rs1, 5);

        // lw x0 never creates a dependency
        drive(OP_LOAD, c_lw, 5'd1, 5'd0, 5'd0, 32'h18, 32'h0);
        step();
        drive(OP_ARITHMETIC, c_add, 5'd0, 5'd0, 5'd6, 32'h1c, 32'h0);
        #1 check("x0_no_stall", bus.o_id_stall, 0);
        step();

        // flw f5 does not block an integer read of x5
        drive(OP_FP_LOAD, c_flw, 5'd2, 5'd0, 5'd5, 32'h20, 32'h0);
        step();
        drive(OP_ARITHMETIC, c_add, 5'd5, 5'd1, 5'd6, 32'h24, 32'h0);
        #1 check("cross_rf_no_stall", bus.o_id_stall, 0);
        step();

        // flw f0 then fadd f1,f0,f2: f0 is a real register
        drive(OP_FP_LOAD, c_flw, 5'd2, 5'd0, 5'd0, 32'h28, 32'h0);
        step();
        drive(OP_FP_ARITHMETIC, c_fadd, 5'd0, 5'd2, 5'd1, 32'h2c, 32'h0);
        #1 check("f0_stall", bus.o_id_stall, 1);
        step();
        check("f0_bubble_valid", bus.o_valid, 0);
        check("f0_bubble_write_fp", bus.o_ctrl.write_fp, 0);
        step();
        check("fadd_arrives_rd", bus.o_rd, 1);

        // flw f3 then fsw f3: FP store data source
        drive(OP_FP_LOAD, c_flw, 5'd2, 5'd0, 5'd3, 32'h30, 32'h0);
        step();
        drive(OP_FP_STORE, c_fsw, 5'd2, 5'd3, 5'd0, 32'h34, 32'h4);
        #1 check("fsw_stall", bus.o_id_stall, 1);
        step();
        check("fsw_bubble_fp_store", bus.o_ctrl.fp_store, 0);
        check("fsw_bubble_web", bus.o_ctrl.WEB, 1);
        step();
        check("fsw_arrives_fp_store", bus.o_ctrl.fp_store, 1);

        // Back-to-back loads: only the adjacent dependency matters
        drive(OP_LOAD, c_lw, 5'd1, 5'd0, 5'd5, 32'h38, 32'h0);
        step();
        drive(OP_LOAD, c_lw, 5'd2, 5'd5, 5'd7, 32'h3c, 32'h0);
        #1 check("lw_rs2_ignored", bus.o_id_stall, 0);
        step();
        drive(OP_ARITHMETIC, c_add, 5'd5, 5'd1, 5'd8, 32'h40, 32'h0);
        #1 check("nonadjacent_no_stall", bus.o_id_stall, 0);
        step();

        // Flush beats load-use
        drive(OP_LOAD, c_lw, 5'd1, 5'd0, 5'd5, 32'h44, 32'h0);
        step();
        drive(OP_JALR, c_jalr, 5'd5, 5'd0, 5'd1, 32'h48, 32'h0);
        #1 check("jalr_lu_stall", bus.o_id_stall, 1);
        bus.i_flush = 1'b1;
        #1 check("flush_no_stall", bus.o_id_stall, 0);
        step();
        check("flush_valid", bus.o_valid, 0);
        check("flush_jump", bus.o_ctrl.jump, 0);
        check("flush_write", bus.o_ctrl.write, 0);
        bus.i_flush = 1'b0;

        // Pass-through store
        drive(OP_STORE, c_sw, 5'd1, 5'd2, 5'd0, 32'h100, 32'h8);
        step();
        check("sw_web", bus.o_ctrl.WEB, 0);
        check("sw_bweb", bus.o_ctrl.BWEB_pre, 2'b10);
        check("sw_pc", bus.o_pc, 32'h100);
        check("sw_imm", bus.o_imm, 32'h8);
        check("sw_valid", bus.o_valid, 1);
        check("sw_rs2_data", bus.o_rs2_data, 32'h102);

        // EX stall for 3 cycles, flush raised during it
        for (int i = 0; i < 3; i++) begin
            bus.i_ex_stall = 1'b1;
            bus.i_flush    = (i >= 1);
            drive(OP_ARITHMETIC, c_add, 5'd3, 5'd4, 5'd9, 32'h200 + 32'(i), 32'h0);
            #1 check("exs_id_stall", bus.o_id_stall, 1);
            step();
            check("exs_pc_frozen", bus.o_pc, 32'h100);
            check("exs_valid_frozen", bus.o_valid, 1);
            check("exs_web_frozen", bus.o_ctrl.WEB, 0);
        end
        bus.i_ex_stall = 1'b0;
        #1 check("release_flush_no_stall", bus.o_id_stall, 0);
        step();
        check("held_flush_valid", bus.o_valid, 0);
        check("held_flush_pc", bus.o_pc, 0);
        bus.i_flush = 1'b0;

        // Reset asserted in the middle of a stall clears at once
        drive(OP_ARITHMETIC, c_add, 5'd3, 5'd4, 5'd9, 32'h300, 32'h0);
        step();
        check("pre_rst_valid", bus.o_valid, 1);
        bus.i_ex_stall = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", bus.o_valid, 0);
        check("midrst_web", bus.o_ctrl.WEB, 1);
        check("midrst_pc", bus.o_pc, 0);
        rst_n          = 1'b1;
        bus.i_ex_stall = 1'b0;
        step();
        check("post_rst_valid", bus.o_valid, 1);
        check("post_rst_pc", bus.o_pc, 32'h300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
